// File: rtl/clock_ctrl_pkg.sv
// Shared types and the BCD-to-7-segment decoder for the HH:MM:SS clock controller.
package clock_ctrl_pkg;

  typedef enum logic {RUN = 1'b0, SET = 1'b1} mode_t;
  typedef enum logic [1:0] {F_H = 2'd0, F_M = 2'd1, F_S = 2'd2} field_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segments, bit0 = a ... bit6 = g.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/clock_ctrl_button_cond.sv
// Push-button conditioner: 2-flop synchroniser, debounce, one-cycle pulse on press.
module button_cond #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          level_reg;
  logic          press_reg;
  logic [CW-1:0] cnt_reg;

  // Everything resets to "released" so a key held through reset never pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      level_reg <= 1'b1;
      press_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= btn_n;
      sync2_reg <= sync1_reg;
      press_reg <= 1'b0;
      if (sync2_reg == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CW'(DEB_CYCLES - 1)) begin
        cnt_reg   <= '0;
        level_reg <= sync2_reg;
        press_reg <= !sync2_reg;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/clock_ctrl.sv
// HH:MM:SS clock controller: BCD timekeeping, RUN/SET state machine, button
// conditioning and registered 7-segment / status LED outputs.
module clock_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int TICK_DIV   = 50_000_000,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       btmode_export,
  input  logic       btsel_export,
  input  logic       btinc_export,
  output logic [6:0] seg7h1_export,
  output logic [6:0] seg7h0_export,
  output logic [6:0] seg7m1_export,
  output logic [6:0] seg7m0_export,
  output logic [6:0] seg7s1_export,
  output logic [6:0] seg7s0_export,
  output logic [7:0] leds_export
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = $clog2(TICK_DIV / 2);

  logic mode_press, sel_press, inc_press;

  button_cond #(.DEB_CYCLES(DEB_CYCLES)) u_btn_mode (
    .clk(clk_clk), .rst_n(reset_reset_n), .btn_n(btmode_export), .press(mode_press));
  button_cond #(.DEB_CYCLES(DEB_CYCLES)) u_btn_sel (
    .clk(clk_clk), .rst_n(reset_reset_n), .btn_n(btsel_export), .press(sel_press));
  button_cond #(.DEB_CYCLES(DEB_CYCLES)) u_btn_inc (
    .clk(clk_clk), .rst_n(reset_reset_n), .btn_n(btinc_export), .press(inc_press));

  function automatic logic [7:0] inc_bcd60(input logic [7:0] v);
    if (v[3:0] == 4'd9)
      return (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] inc_bcd24(input logic [7:0] v);
    if (v == 8'h23)
      return 8'h00;
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Time packed as {h1, h0, m1, m0, s1, s0}, one BCD digit per nibble.
  logic [23:0]   time_reg, time_next;
  mode_t         mode_reg, mode_next;
  field_t        field_reg, field_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic [BW-1:0] blink_cnt_reg, blink_cnt_next;
  logic          blink_vis_reg, blink_vis_next;
  logic          heartbeat_reg, heartbeat_next;
  logic          tick;

  assign tick = (mode_reg == RUN) && (presc_reg == PW'(TICK_DIV - 1));

  always_comb begin
    time_next      = time_reg;
    mode_next      = mode_reg;
    field_next     = field_reg;
    presc_next     = presc_reg;
    blink_cnt_next = blink_cnt_reg;
    blink_vis_next = blink_vis_reg;
    heartbeat_next = heartbeat_reg;
    if (mode_reg == RUN) begin
      presc_next     = tick ? '0 : presc_reg + PW'(1);
      blink_cnt_next = '0;
      blink_vis_next = 1'b1;
      if (tick) begin
        heartbeat_next  = !heartbeat_reg;
        time_next[7:0]  = inc_bcd60(time_reg[7:0]);
        if (time_reg[7:0] == 8'h59) begin
          time_next[15:8] = inc_bcd60(time_reg[15:8]);
          if (time_reg[15:8] == 8'h59)
            time_next[23:16] = inc_bcd24(time_reg[23:16]);
        end
      end
      // A tick in the same cycle is still applied before entering SET.
      if (mode_press) begin
        mode_next      = SET;
        field_next     = F_H;
        presc_next     = '0;
        blink_cnt_next = '0;
        blink_vis_next = 1'b1;
      end
    end else begin
      presc_next = '0;
      if (blink_cnt_reg == BW'(TICK_DIV / 2 - 1)) begin
        blink_cnt_next = '0;
        blink_vis_next = !blink_vis_reg;
      end else begin
        blink_cnt_next = blink_cnt_reg + BW'(1);
      end
      if (mode_press) begin
        mode_next = RUN;
      end else if (sel_press) begin
        case (field_reg)
          F_H:     field_next = F_M;
          F_M:     field_next = F_S;
          default: field_next = F_H;
        endcase
      end else if (inc_press) begin
        blink_cnt_next = '0;
        blink_vis_next = 1'b1;
        case (field_reg)
          F_H:     time_next[23:16] = inc_bcd24(time_reg[23:16]);
          F_M:     time_next[15:8]  = inc_bcd60(time_reg[15:8]);
          default: time_next[7:0]   = inc_bcd60(time_reg[7:0]);
        endcase
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      time_reg      <= '0;
      mode_reg      <= RUN;
      field_reg     <= F_H;
      presc_reg     <= '0;
      blink_cnt_reg <= '0;
      blink_vis_reg <= 1'b1;
      heartbeat_reg <= 1'b0;
    end else begin
      time_reg      <= time_next;
      mode_reg      <= mode_next;
      field_reg     <= field_next;
      presc_reg     <= presc_next;
      blink_cnt_reg <= blink_cnt_next;
      blink_vis_reg <= blink_vis_next;
      heartbeat_reg <= heartbeat_next;
    end
  end

  logic       blank_sel;
  logic [5:0] blank_digit;
  logic [2:0] field_oh;

  assign blank_sel   = (mode_reg == SET) && !blink_vis_reg;
  assign blank_digit = {{2{blank_sel && (field_reg == F_H)}},
                        {2{blank_sel && (field_reg == F_M)}},
                        {2{blank_sel && (field_reg == F_S)}}};

  always_comb begin
    field_oh = 3'b000;
    if (mode_reg == SET) begin
      case (field_reg)
        F_H:     field_oh = 3'b100;
        F_M:     field_oh = 3'b010;
        F_S:     field_oh = 3'b001;
        default: field_oh = 3'b000;
      endcase
    end
  end

  logic [6:0] seg_out [6];

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_seg
      logic [6:0] seg_reg;
      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n)
          seg_reg <= 7'h40;
        else
          seg_reg <= blank_digit[gi] ? SEG_BLANK : bcd_to_seg(time_reg[4*gi +: 4]);
      end
      assign seg_out[gi] = seg_reg;
    end
  endgenerate

  logic [7:0] leds_reg;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)
      leds_reg <= 8'h00;
    else
      leds_reg <= {mode_reg == SET, 3'b000, heartbeat_reg, field_oh};
  end

  assign seg7s0_export = seg_out[0];
  assign seg7s1_export = seg_out[1];
  assign seg7m0_export = seg_out[2];
  assign seg7m1_export = seg_out[3];
  assign seg7h0_export = seg_out[4];
  assign seg7h1_export = seg_out[5];
  assign leds_export   = leds_reg;

endmodule

// File: doc/clock_ctrl.md
# clock_ctrl

Controller for the board's HH:MM:SS clock display. It keeps time in BCD from a cycle prescaler and conditions the three push-buttons (mode, select, increment). It also runs the RUN/SET state machine and drives the six 7-segment digits plus eight status LEDs. It sits between the board pins and the exported seg7/led/button PIO ports of `system`, and owns all timekeeping so software only observes.

## Interface
- `TICK_DIV`, default 50_000_000: clock cycles per second. Minimum 4, even.
- `DEB_CYCLES`, default 1_000_000: cycles a button level must be stable before it is accepted.
- `clk_clk`  in  1  system clock.
- `reset_reset_n`  in  1  reset, asynchronous assert, active-low.
- `btmode_export`  in  1  raw mode key, active-low, asynchronous to `clk_clk`.
- `btsel_export`  in  1  raw field-select key, active-low, asynchronous.
- `btinc_export`  in  1  raw increment key, active-low, asynchronous.
- `seg7h1_export` / `seg7h0_export`  out  7  hours tens/units, active-low segments, bit0=a … bit6=g.
- `seg7m1_export` / `seg7m0_export`  out  7  minutes tens/units.
- `seg7s1_export` / `seg7s0_export`  out  7  seconds tens/units.
- `leds_export`  out  8  status: [7]=SET mode, [6:4]=0, [3]=seconds heartbeat, [2:0]=one-hot field (2=H, 1=M, 0=S; 000 in RUN).
- One clock domain; reset asynchronous, active-low.

## Operation
- Button path per key: 2-flop synchroniser, then a debounce counter that accepts the new level after DEB_CYCLES consecutive equal samples, then a 1-cycle pulse on the accepted press (high→low). Release produces no pulse.
- State machine RUN ↔ SET, toggled by a mode pulse.
  - Entering SET selects field H and sets blink phase to visible.
  - Leaving SET clears the prescaler to 0.
- RUN:
  - The prescaler counts 0..TICK_DIV-1; at TICK_DIV-1 it emits a tick.
  - Each tick increments seconds with full carry: 59→00 carries to minutes, 59→00 carries to hours, 23→00. 23:59:59 → 00:00:00.
  - sel and inc pulses are ignored.
  - leds[3] toggles on every tick.
- SET:
  - Time is frozen and the prescaler is held at 0.
  - sel cycles the field H→M→S→H.
  - inc increments only the selected field, wrapping (H 23→00, M/S 59→00) with no carry, and resets blink phase to visible.
  - The blink counter toggles phase every TICK_DIV/2 cycles. In the blank phase both digits of the selected field output 7'h7F.
- Simultaneous pulses in one cycle, priority mode > sel > inc. Lower-priority pulses that cycle are dropped, not queued.
- Decode:
  - BCD 0-9 maps to the standard active-low pattern: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
  - Out-of-range codes map to 7'h7F. They are unreachable.

## Timing
- Reset values:
  - Time 00:00:00, so all seg outputs = 7'h40.
  - leds = 8'h00, state RUN, prescaler 0, blink visible.
  - Debouncers hold level "released", so a key held through reset gives no pulse.
- Press-to-pulse latency: 2 sync cycles + DEB_CYCLES.
- Pulse-to-effect: state/time registers update on the clock edge following the pulse cycle. Seg/led outputs are registered and update one further cycle later.
- Tick-to-display latency: 2 cycles from the prescaler reaching TICK_DIV-1.
- A mode pulse coinciding with a tick: the tick is applied, then the state enters SET. The counter is frozen from the next cycle.
- Glitches shorter than DEB_CYCLES never produce a pulse.

## Structure
- Package `clock_ctrl_pkg`:
  - `mode_t` {RUN, SET}
  - `field_t` {F_H, F_M, F_S}
  - `SEG_BLANK` = 7'h7F
  - function `bcd_to_seg`
- Sub-module `button_cond` (synchroniser + debounce + press pulse), parameterised by DEB_CYCLES, instantiated 3×.
- Time kept as six 4-bit BCD digits; no binary-to-BCD conversion.

## Test plan
All scenarios use TICK_DIV=10, DEB_CYCLES=4.
- Reset, then 30 cycles with no input → time 00:00:03; leds[3] toggles 3 times.
- Preload by SET to 23:59:59, return to RUN, wait 10 cycles → 00:00:00 on all digits; leds[2:0]=000.
- Press mode → leds=8'h84. Press inc ×25 → hours 01, with no carry into minutes. Press sel, then inc ×61 → minutes 01.
- In SET, observe the selected field → 7'h7F for 5 cycles, then digits visible for 5 cycles. An inc press restores visible immediately.
- Bounce: btinc low 3 cycles, high 1, low 3 → no increment. Held low ≥ 7 cycles → exactly 1 increment. Release then re-press → second increment.
- Drive mode and inc pulses in the same cycle (force both keys simultaneously) → mode toggles, time unchanged. Reset asserted mid-SET → immediate RUN, 00:00:00, leds 00.
